// File: rtl/egress_port_tx.sv
// rtl/egress_port_tx.sv - FIFO-to-stream egress transmitter with SOP/EOP framing checks and packet counter
// Optional feature macro: INTER_PKT_GAP_EN (idle gap of IPG_CYCLES clocks after every accepted EOP).
module egress_port_tx #(
  parameter int FIFO_W     = 34,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int IPG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rdEnable,
  input  logic [FIFO_W-1:0] fifo_outData,
  input  logic              fifo_empty,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  input  logic              tx_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_framing
);

  if (FIFO_W != DATA_W + 2 || IPG_CYCLES < 1) begin : g_bad_cfg
    $error("egress_port_tx: FIFO_W must equal DATA_W+2 and IPG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_HOLD    = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t state;
  state_t state_n;
  logic   in_pkt;

  logic              w_sop;
  logic              w_eop;
  logic [DATA_W-1:0] w_data;
  logic              orphan;
  logic              accept;

  assign w_sop  = fifo_outData[FIFO_W-1];
  assign w_eop  = fifo_outData[FIFO_W-2];
  assign w_data = fifo_outData[DATA_W-1:0];
  assign orphan = !in_pkt && !w_sop;
  assign accept = tx_valid && tx_ready;

`ifdef INTER_PKT_GAP_EN
  localparam int GAP_W = $clog2(IPG_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        state_n = orphan ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (accept) begin
          if (!fifo_empty) state_n = S_RD_WAIT;
          else             state_n = S_IDLE;
`ifdef INTER_PKT_GAP_EN
          if (tx_eop) state_n = S_GAP;
`endif
        end
      end
`ifdef INTER_PKT_GAP_EN
      S_GAP: begin
        if (gap_cnt == GAP_W'(IPG_CYCLES - 1)) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // The read strobe must agree exactly with the transitions into RD_WAIT above.
  always_comb begin
    rdEnable = 1'b0;
    case (state)
      S_IDLE: rdEnable = !fifo_empty;
      S_HOLD: begin
        rdEnable = accept && !fifo_empty;
`ifdef INTER_PKT_GAP_EN
        if (tx_eop) rdEnable = 1'b0;
`endif
      end
      default: rdEnable = 1'b0;
    endcase
    if (!reset) rdEnable = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_sop      <= 1'b0;
      tx_eop      <= 1'b0;
      in_pkt      <= 1'b0;
      pkt_count   <= '0;
      err_framing <= 1'b0;
    end else begin
      err_framing <= 1'b0;
      case (state)
        S_RD_WAIT: begin
          // A second SOP is flagged but still starts a fresh packet.
          err_framing <= orphan || (w_sop && in_pkt);
          if (!orphan) begin
            tx_valid <= 1'b1;
            tx_data  <= w_data;
            tx_sop   <= w_sop;
            tx_eop   <= w_eop;
          end
        end
        S_HOLD: begin
          if (accept) begin
            tx_valid <= 1'b0;
            in_pkt   <= (tx_sop || in_pkt) && !tx_eop;
            if (tx_eop) pkt_count <= pkt_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_egress_port_tx.sv
// tb/tb_egress_port_tx.sv - directed plus randomized bench for egress_port_tx against a packet-sequence model
// Honours INTER_PKT_GAP_EN when defined for the design build.
module tb_egress_port_tx;

  localparam int DW = 32;
  localparam int FW = 34;
  localparam int CW = 4;
`ifdef INTER_PKT_GAP_EN
  localparam int GAP_EXP = 13;
`else
  localparam int GAP_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rdEnable;
  logic [FW-1:0] fifo_outData;
  logic          fifo_empty;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic          tx_ready;
  logic [CW-1:0] pkt_count;
  logic          err_framing;

  always #5 clk = ~clk;

  egress_port_tx #(
    .FIFO_W(FW), .DATA_W(DW), .CNT_W(CW), .IPG_CYCLES(12)
  ) dut (
    .clk(clk), .reset(reset), .rdEnable(rdEnable), .fifo_outData(fifo_outData),
    .fifo_empty(fifo_empty), .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .tx_ready(tx_ready), .pkt_count(pkt_count), .err_framing(err_framing)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] q[$];
  logic [FW-1:0] pend[$];
  logic [FW-1:0] exp_beats[$];
  int            exp_cnt = 0;
  int            exp_err = 0;
  int            obs_err = 0;
  int            n_acc = 0;
  int            n_valid = 0;
  int            n_stall = 0;
  bit            m_in_pkt = 0;
  bit            rd_seen = 0;
  bit            stall_prev = 0;
  bit            ready_next = 1;
  logic [FW-1:0] prev_beat = '0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequence-level model: each pushed word is either dropped as an orphan or becomes the next beat.
  task automatic push(input bit sop, input bit eop, input logic [31:0] d);
    pend.push_back({sop, eop, d});
    if (!m_in_pkt && !sop) begin
      exp_err++;
    end else begin
      if (sop && m_in_pkt) exp_err++;
      exp_beats.push_back({sop, eop, d});
      m_in_pkt = (sop || m_in_pkt) && !eop;
    end
  endtask

  task automatic tick();
    logic [FW-1:0] e;
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) fifo_outData = q.pop_front();
    while (pend.size() > 0) q.push_back(pend.pop_front());
    fifo_empty = (q.size() == 0);
    tx_ready = ready_next;
    @(negedge clk);
    chk("rd_while_empty", rdEnable & fifo_empty, 0);
    chk("pkt_count", pkt_count, exp_cnt % 16);
    if (stall_prev) chk("hold_stable", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, prev_beat});
    if (tx_valid && !tx_ready) chk("rd_during_stall", rdEnable, 0);
    if (err_framing) obs_err++;
    if (tx_valid) n_valid++;
    if (tx_valid && tx_ready) begin
      chk("beat_expected", exp_beats.size() > 0, 1);
      if (exp_beats.size() > 0) begin
        e = exp_beats.pop_front();
        chk("beat", {tx_sop, tx_eop, tx_data}, e);
        if (e[FW-2]) exp_cnt++;
      end
      n_acc++;
    end
    stall_prev = tx_valid && !tx_ready;
    if (stall_prev) n_stall++;
    prev_beat = {tx_sop, tx_eop, tx_data};
    rd_seen = rdEnable;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_beats.size() > 0 || q.size() > 0 || pend.size() > 0 || tx_valid || rd_seen) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < max, 1);
    repeat (3) tick();
  endtask

  initial begin
    int edges, n, e0, v0, a0, s0, len;

    reset = 1'b0;
    fifo_empty = 1'b1;
    fifo_outData = '0;
    tx_ready = 1'b1;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_outputs", {tx_data, tx_sop, tx_eop, err_framing, rdEnable}, 0);
    chk("rst_pkt_count", pkt_count, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // single-word packet plus empty-to-valid latency
    push(1, 1, 32'h55);
    tick();
    edges = 0;
    while (!tx_valid && edges < 10) begin
      tick();
      edges++;
    end
    chk("latency", edges, 2);
    chk("single_sop_eop", {tx_sop, tx_eop, tx_data}, {2'b11, 32'h55});
    drain(50);
    chk("single_cnt", pkt_count, 1);
    chk("single_no_err", obs_err, 0);

    // three-word packet, sink stalls on beat 2
    a0 = n_acc;
    s0 = n_stall;
    push(1, 0, 32'hA0);
    push(0, 0, 32'hA1);
    push(0, 1, 32'hA2);
    n = 0;
    while (n_acc == a0 && n < 20) begin
      tick();
      n++;
    end
    ready_next = 0;
    repeat (6) tick();
    ready_next = 1;
    drain(50);
    chk("pkt3_beats", n_acc - a0, 3);
    chk("pkt3_stall_seen", (n_stall - s0) >= 4, 1);
    chk("pkt3_cnt", pkt_count, 2);
    chk("pkt3_no_err", obs_err, 0);

    // orphan word while idle
    e0 = obs_err;
    v0 = n_valid;
    push(0, 0, 32'hDEAD);
    drain(50);
    chk("orphan_err_pulse", obs_err - e0, 1);
    chk("orphan_no_valid", n_valid - v0, 0);
    chk("orphan_cnt", pkt_count, 2);

    // second SOP inside a packet
    e0 = obs_err;
    a0 = n_acc;
    push(1, 0, 32'h1);
    push(1, 0, 32'h2);
    push(0, 1, 32'h3);
    drain(50);
    chk("dsop_err", obs_err - e0, 1);
    chk("dsop_beats", n_acc - a0, 3);
    chk("dsop_cnt", pkt_count, 3);

    // back-to-back single-word packets: spacing from EOP accept to next read
    a0 = n_acc;
    push(1, 1, 32'h11);
    push(1, 1, 32'h22);
    n = 0;
    while (n_acc == a0 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (!rdEnable && n < 40) begin
      tick();
      n++;
    end
    chk("ipg_spacing", n, GAP_EXP);
    drain(80);
    chk("b2b_cnt", pkt_count, 5);

    // asynchronous reset while a word is held
    ready_next = 0;
    push(1, 0, 32'hBEEF);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold_reached", tx_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_cnt", pkt_count, 0);
    chk("async_rst_err", err_framing, 0);
    exp_beats.delete();
    q.delete();
    pend.delete();
    m_in_pkt = 0;
    exp_cnt = 0;
    stall_prev = 0;
    rd_seen = 0;
    fifo_empty = 1'b1;
    ready_next = 1;
    repeat (2) tick();
    reset = 1'b1;
    e0 = obs_err;
    push(1, 0, 32'h1234);
    push(0, 1, 32'h5678);
    drain(50);
    chk("post_rst_cnt", pkt_count, 1);
    chk("post_rst_no_err", obs_err - e0, 0);

    // randomized traffic with stray words, missing EOPs and sink back-pressure
    for (int p = 0; p < 80; p++) begin
      len = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) push(0, 0, $urandom);
      for (int j = 0; j < len; j++) push(j == 0, (j == len - 1) && ($urandom_range(0, 9) != 0), $urandom);
      repeat ($urandom_range(0, 6)) begin
        ready_next = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    ready_next = 1;
    push(1, 1, 32'hF00D);
    drain(4000);
    chk("rand_err_total", obs_err, exp_err);
    chk("rand_beats_left", exp_beats.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
